fsqrt_sequencer: RTL and testbench

//  Single-precision IEEE-754 square-root controller around the 32-bit Goldschmidt root core.
//  - Accepts operands from the FPU issue stage over valid/ready.
//  - Handles special operands, normalizes the mantissa into core radicand form and sequences core start/ready.
//  - Rounds the root and presents the packed result with backpressure; supports pipeline flush.

---
 rtl/fsqrt_sequencer.sv | 156 +++++++++++++++
 tb/tb_fsqrt_sequencer.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fsqrt_sequencer.sv
// IEEE-754 single-precision square-root sequencer around a Goldschmidt root core.
// Decodes specials, normalises the radicand, drives core start/ready, rounds and holds the result.
module fsqrt_sequencer #(
   parameter bit          ROUND_NEAREST = 1'b1,
   parameter logic [31:0] QNAN          = 32'h7FC00000
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_a,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_invalid,
   output logic        root_start,
   output logic [31:0] root_d,
   input  logic        root_busy,
   input  logic        root_ready,
   input  logic [31:0] root_q
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      DONE,
      DRAIN
   } state_t;

   state_t      state, state_nxt;
   logic [31:0] root_d_nxt;
   logic [31:0] result_r, result_nxt;
   logic        invalid_r, invalid_nxt;
   logic [7:0]  exp_r, exp_nxt;

   // operand decode
   logic        op_sign;
   logic [7:0]  op_exp;
   logic [22:0] op_man;
   logic        is_special;
   logic [31:0] special_result;
   logic        special_invalid;
   logic [8:0]  exp_sum;

   assign op_sign = in_a[31];
   assign op_exp  = in_a[30:23];
   assign op_man  = in_a[22:0];
   assign exp_sum = {1'b0, op_exp} + 9'd127;

   always_comb begin
      is_special      = 1'b1;
      special_result  = '0;
      special_invalid = 1'b0;
      if (op_exp == 8'hFF && op_man != 23'd0) begin
         special_result  = QNAN;
         special_invalid = 1'b1;
      end else if (op_sign && op_exp != 8'h00) begin
         special_result  = QNAN;
         special_invalid = 1'b1;
      end else if (op_exp == 8'h00) begin
         special_result  = {op_sign, 31'd0};
      end else if (op_exp == 8'hFF) begin
         special_result  = 32'h7F800000;
      end else begin
         is_special      = 1'b0;
      end
   end

   // result assembly: round on q[7], mantissa carry-out bumps the exponent
   logic        round_bit;
   logic        man_carry;
   logic [22:0] man_rounded;
   logic [7:0]  exp_out;
   logic [31:0] assembled;
   logic        unused_q_bits;

   assign round_bit                = ROUND_NEAREST & root_q[7];
   assign {man_carry, man_rounded} = {1'b0, root_q[30:8]} + {23'd0, round_bit};
   assign exp_out                  = exp_r + {7'd0, man_carry};
   assign assembled                = {1'b0, exp_out, man_rounded};
   assign unused_q_bits            = ^{root_q[31], root_q[6:0]};

   assign in_ready    = (state == IDLE);
   assign out_valid   = (state == DONE);
   assign out_result  = result_r;
   assign out_invalid = invalid_r;

   always_comb begin
      state_nxt   = state;
      root_d_nxt  = root_d;
      result_nxt  = result_r;
      invalid_nxt = invalid_r;
      exp_nxt     = exp_r;
      root_start  = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid && !flush) begin
               if (is_special) begin
                  result_nxt  = special_result;
                  invalid_nxt = special_invalid;
                  state_nxt   = DONE;
               end else begin
                  root_d_nxt = op_exp[0] ? {2'b01, op_man, 7'd0} : {1'b1, op_man, 8'd0};
                  exp_nxt    = exp_sum[8:1];
                  state_nxt  = START;
               end
            end
         end
         START: begin
            root_start = !root_busy;
            // once the pulse issues the core cannot be cancelled, so its result must be drained
            if (flush)
               state_nxt = root_busy ? IDLE : DRAIN;
            else if (!root_busy)
               state_nxt = WAIT;
         end
         WAIT: begin
            if (flush) begin
               state_nxt = DRAIN;
            end else if (root_ready) begin
               result_nxt  = assembled;
               invalid_nxt = 1'b0;
               state_nxt   = DONE;
            end
         end
         DONE: begin
            if (flush || out_ready)
               state_nxt = IDLE;
         end
         DRAIN: begin
            if (root_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         root_d    <= '0;
         result_r  <= '0;
         invalid_r <= 1'b0;
         exp_r     <= '0;
      end else begin
         state     <= state_nxt;
         root_d    <= root_d_nxt;
         result_r  <= result_nxt;
         invalid_r <= invalid_nxt;
         exp_r     <= exp_nxt;
      end
   end

endmodule

// File: tb/tb_fsqrt_sequencer.sv
// Scoreboarded bench for fsqrt_sequencer with a behavioural root core model.
module tb_fsqrt_sequencer;

   localparam int CORE_LAT = 6;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] in_a = '0;
   logic        flush = 1'b0;
   logic        out_ready = 1'b1;
   logic        in_ready, out_valid, out_invalid, root_start;
   logic [31:0] out_result, root_d;
   logic        root_busy;
   logic        root_ready;
   logic [31:0] root_q;

   logic        core_busy;
   logic        busy_extra = 1'b0;
   int          core_cnt;
   logic [31:0] core_d;
   int          starts = 0;
   int          readies = 0;
   int          errors = 0;
   int          checks = 0;

   typedef struct {
      logic [31:0] res;
      logic        inv;
      int          tol;
      string       name;
   } exp_t;
   exp_t sb[$];

   always #5 clock = ~clock;

   assign root_busy = core_busy | busy_extra;

   fsqrt_sequencer #(.ROUND_NEAREST(1'b1), .QNAN(32'h7FC00000)) dut (
      .clock(clock), .resetn(resetn),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_invalid(out_invalid),
      .root_start(root_start), .root_d(root_d),
      .root_busy(root_busy), .root_ready(root_ready), .root_q(root_q)
   );

   function automatic logic [31:0] isqrt(input logic [31:0] d);
      logic [63:0] n;
      logic [63:0] t;
      logic [31:0] r;
      n = {d, 32'h0};
      r = '0;
      for (int i = 31; i >= 0; i--) begin
         t = {32'h0, r | (32'h1 << i)};
         if (t * t <= n) r = r | (32'h1 << i);
      end
      return r;
   endfunction

   // core model: fixed latency, truncated root of the radicand
   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         core_busy  <= 1'b0;
         root_ready <= 1'b0;
         core_cnt   <= 0;
         core_d     <= '0;
         root_q     <= '0;
      end else begin
         root_ready <= 1'b0;
         if (core_busy) begin
            if (core_cnt == 1) begin
               core_busy  <= 1'b0;
               root_ready <= 1'b1;
               root_q     <= isqrt(core_d);
            end
            core_cnt <= core_cnt - 1;
         end else if (root_start) begin
            core_busy <= 1'b1;
            core_cnt  <= CORE_LAT;
            core_d    <= root_d;
         end
      end
   end

   always @(posedge clock) begin
      if (root_start) starts <= starts + 1;
      if (root_ready) readies <= readies + 1;
   end

   task automatic send_op(input logic [31:0] a, input bit push, input logic [31:0] res,
                          input logic inv, input int tol, input string name);
      int n = 0;
      in_a = a;
      in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("FAIL accept_%s: in_ready=%b after %0d cycles, required 1", name, in_ready, n);
         in_valid = 1'b0;
         return;
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
      if (push) sb.push_back('{res, inv, tol, name});
   endtask

   task automatic wait_out(output bit ok);
      int n = 0;
      while (!out_valid && n < 200) begin
         @(posedge clock); #1;
         n++;
      end
      ok = out_valid;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if ({in_ready, out_valid, out_invalid, root_start} !== 4'b1000) begin
         errors++;
         $display("FAIL reset_ctrl: {in_ready,out_valid,out_invalid,root_start}=%b, required 1000",
                  {in_ready, out_valid, out_invalid, root_start});
      end
      checks++;
      if (out_result !== 32'h0 || root_d !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: out_result=%h root_d=%h, required 0 and 0", out_result, root_d);
      end
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_normal();
      logic [31:0] ops  [5] = '{32'h40800000, 32'h3F800000, 32'h3E800000, 32'h40000000, 32'h40400000};
      logic [31:0] exps [5] = '{32'h40000000, 32'h3F800000, 32'h3F000000, 32'h3FB504F3, 32'h3FDDB3D7};
      int          tols [5] = '{0, 0, 0, 1, 1};
      bit          ok;
      exp_t        e;
      int          s0;
      int unsigned diff;
      for (int i = 0; i < 5; i++) begin
         s0 = starts;
         send_op(ops[i], 1'b1, exps[i], 1'b0, tols[i], "normal");
         if (i == 0) begin
            checks++;
            if (root_start !== 1'b1 || root_d !== 32'h40000000) begin
               errors++;
               $display("FAIL start_latency: root_start=%b root_d=%h, required 1 and 40000000",
                        root_start, root_d);
            end
         end
         wait_out(ok);
         checks++;
         if (!ok || sb.size() == 0) begin
            errors++;
            $display("FAIL normal_timeout[%0d]: out_valid=%b queued=%0d, required 1 and 1",
                     i, out_valid, sb.size());
         end else begin
            e = sb.pop_front();
            diff = (out_result > e.res) ? out_result - e.res : e.res - out_result;
            if (diff > e.tol || out_invalid !== e.inv) begin
               errors++;
               $display("FAIL %s[%0d]: result=%h inv=%b, required %h (tol %0d) inv=%b",
                        e.name, i, out_result, out_invalid, e.res, e.tol, e.inv);
            end
         end
         @(posedge clock); #1;
         checks++;
         if (starts - s0 != 1) begin
            errors++;
            $display("FAIL normal_starts[%0d]: root_start pulses=%0d, required 1", i, starts - s0);
         end
      end
   endtask

   task automatic test_specials();
      logic [31:0] ops  [5] = '{32'hBF800000, 32'h7F800001, 32'h80000000, 32'h00000001, 32'h7F800000};
      logic [31:0] exps [5] = '{32'h7FC00000, 32'h7FC00000, 32'h80000000, 32'h00000000, 32'h7F800000};
      logic        invs [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      exp_t        e;
      int          s0;
      for (int i = 0; i < 5; i++) begin
         s0 = starts;
         send_op(ops[i], 1'b1, exps[i], invs[i], 0, "special");
         checks++;
         if (out_valid !== 1'b1 || sb.size() == 0) begin
            errors++;
            $display("FAIL special_latency[%0d]: out_valid=%b one cycle after accept, required 1",
                     i, out_valid);
         end else begin
            e = sb.pop_front();
            if (out_result !== e.res || out_invalid !== e.inv) begin
               errors++;
               $display("FAIL %s[%0d]: result=%h inv=%b, required %h inv=%b",
                        e.name, i, out_result, out_invalid, e.res, e.inv);
            end
         end
         @(posedge clock); #1;
         checks++;
         if (starts != s0) begin
            errors++;
            $display("FAIL special_starts[%0d]: root_start pulses=%0d, required 0", i, starts - s0);
         end
      end
   endtask

   task automatic test_backpressure();
      bit          ok;
      bit          stable = 1'b1;
      bit          rdy_seen = 1'b0;
      logic [31:0] held;
      exp_t        e;
      int          s0;
      out_ready = 1'b0;
      s0 = starts;
      send_op(32'h3F800000, 1'b1, 32'h3F800000, 1'b0, 0, "backpressure");
      wait_out(ok);
      held = out_result;
      for (int i = 0; i < 10; i++) begin
         in_valid = i[0];
         in_a = 32'h40800000;
         @(posedge clock); #1;
         if (!out_valid || out_result !== held) stable = 1'b0;
         if (in_ready) rdy_seen = 1'b1;
      end
      in_valid = 1'b0;
      checks++;
      if (!ok || !stable || rdy_seen) begin
         errors++;
         $display("FAIL hold_stable: valid=%b stable=%b in_ready_seen=%b, required 1 1 0",
                  ok, stable, rdy_seen);
      end
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL backpressure_queue: queued=0, required 1");
      end else begin
         e = sb.pop_front();
         if (held !== e.res || out_invalid !== e.inv) begin
            errors++;
            $display("FAIL %s: result=%h inv=%b, required %h inv=%b", e.name, held, out_invalid,
                     e.res, e.inv);
         end
      end
      out_ready = 1'b1;
      @(posedge clock); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL release_idle: in_ready=%b out_valid=%b, required 1 and 0", in_ready, out_valid);
      end
      repeat (3) @(posedge clock);
      #1;
      checks++;
      if (out_valid !== 1'b0 || starts - s0 != 1) begin
         errors++;
         $display("FAIL held_pulses_dropped: out_valid=%b starts=%0d, required 0 and 1",
                  out_valid, starts - s0);
      end
   endtask

   task automatic test_flush();
      bit   ok;
      bit   spurious = 1'b0;
      exp_t e;
      int   s0, r0, n;
      // flush in WAIT, next op offered at once
      s0 = starts;
      r0 = readies;
      send_op(32'h40800000, 1'b0, 32'h0, 1'b0, 0, "flush_wait");
      @(posedge clock); #1;
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      in_a = 32'h40800000;
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 200) begin
         if (out_valid) spurious = 1'b1;
         @(posedge clock); #1;
         n++;
      end
      checks++;
      if (spurious || n == 0 || readies == r0) begin
         errors++;
         $display("FAIL drain_gate: spurious=%b wait=%0d drained=%0d, required 0 >0 >0",
                  spurious, n, readies - r0);
      end
      send_op(32'h40800000, 1'b1, 32'h40000000, 1'b0, 0, "after_flush");
      wait_out(ok);
      checks++;
      if (!ok || sb.size() == 0) begin
         errors++;
         $display("FAIL after_flush_timeout: out_valid=%b, required 1", out_valid);
      end else begin
         e = sb.pop_front();
         if (out_result !== e.res || out_invalid !== e.inv) begin
            errors++;
            $display("FAIL %s: result=%h inv=%b, required %h inv=%b", e.name, out_result,
                     out_invalid, e.res, e.inv);
         end
      end
      @(posedge clock); #1;
      checks++;
      if (starts - s0 != 2) begin
         errors++;
         $display("FAIL flush_starts: root_start pulses=%0d, required 2", starts - s0);
      end
      // flush in START while the core is still busy
      busy_extra = 1'b1;
      s0 = starts;
      send_op(32'h40800000, 1'b0, 32'h0, 1'b0, 0, "flush_start");
      @(posedge clock); #1;
      checks++;
      if (root_start !== 1'b0 || root_d !== 32'h40000000 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL start_stall: root_start=%b root_d=%h in_ready=%b, required 0 40000000 0",
                  root_start, root_d, in_ready);
      end
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || starts != s0) begin
         errors++;
         $display("FAIL flush_start: in_ready=%b starts=%0d, required 1 and 0", in_ready, starts - s0);
      end
      busy_extra = 1'b0;
      // flush in DONE
      out_ready = 1'b0;
      send_op(32'h80000000, 1'b0, 32'h0, 1'b0, 0, "flush_done");
      flush = 1'b1;
      @(posedge clock); #1;
      flush = 1'b0;
      out_ready = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL flush_done: out_valid=%b in_ready=%b, required 0 and 1", out_valid, in_ready);
      end
   endtask

   task automatic test_async_reset();
      bit   ok;
      exp_t e;
      send_op(32'h40800000, 1'b0, 32'h0, 1'b0, 0, "reset_wait");
      @(posedge clock); #3;
      resetn = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, out_invalid, root_start} !== 4'b1000 ||
          out_result !== 32'h0 || root_d !== 32'h0) begin
         errors++;
         $display("FAIL async_reset: ctrl=%b result=%h root_d=%h, required 1000 0 0",
                  {in_ready, out_valid, out_invalid, root_start}, out_result, root_d);
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      resetn = 1'b1;
      @(posedge clock); #1;
      send_op(32'h41100000, 1'b1, 32'h40400000, 1'b0, 0, "post_reset");
      wait_out(ok);
      checks++;
      if (!ok || sb.size() == 0) begin
         errors++;
         $display("FAIL post_reset_timeout: out_valid=%b, required 1", out_valid);
      end else begin
         e = sb.pop_front();
         if (out_result !== e.res || out_invalid !== e.inv) begin
            errors++;
            $display("FAIL %s: result=%h inv=%b, required %h inv=%b", e.name, out_result,
                     out_invalid, e.res, e.inv);
         end
      end
      @(posedge clock); #1;
   endtask

   initial begin
      test_reset();
      test_normal();
      test_specials();
      test_backpressure();
      test_flush();
      test_async_reset();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
